// File: rtl/uart_pkg.sv
// Shared UART types, stop-bit encodings and frame-size helpers.
// Used by the Tx serialiser and the shared bit timer.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  typedef logic [1:0] stop_cfg_t;

  localparam stop_cfg_t STOP_1   = 2'b00;
  localparam stop_cfg_t STOP_1P5 = 2'b01;
  localparam stop_cfg_t STOP_2   = 2'b10;

  // Wide enough for 2 * OVERSAMPLE with OVERSAMPLE up to 32.
  localparam int unsigned TICK_W = 7;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int unsigned max_bits);
    if (req < 4'd5) return 4'd5;
    if (32'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

  function automatic logic [TICK_W-1:0] stop_ticks(input stop_cfg_t cfg,
                                                   input int unsigned os);
    case (cfg)
      STOP_1:   return TICK_W'(os);
      STOP_1P5: return TICK_W'((os * 3) / 2);
      default:  return TICK_W'(2 * os);
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud_ce pulses and flags the last pulse of a period of 'length' pulses.
// load clears the count; shared with the Rx path.
module uart_bit_timer #(
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_ce,
  input  logic             load,
  input  logic [Width-1:0] length,
  output logic             period_done
);

  logic [Width-1:0] cnt_q;

  // Not gated by load: load is driven from the handshake that itself uses period_done.
  assign period_done = baud_ce && (cnt_q == length - Width'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (baud_ce) begin
      cnt_q <= period_done ? '0 : cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmit serialiser with valid/ready handshake and back-to-back frames.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned MAX_BITS   = 9,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_ce,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [3:0]          num_bits,
  input  logic [1:0]          stop_cfg,
  input  logic                parity_en,
  input  logic                parity_ev,
  input  logic                parity_stick,
  input  logic                break_en,
`ifdef UART_TX_CTS_EN
  input  logic                cts_n,
`endif
  output logic                stx,
  output logic                busy_n
);

  tx_state_t           state_q;
  logic [MAX_BITS-1:0] shift_q;
  logic [3:0]          bit_cnt_q;
  logic                par_q;
  logic                par_en_q;
  stop_cfg_t           stop_q;
  logic                stx_q;
  logic                busy_n_q;

  logic                cts_ok;
  logic                period_done;
  logic                accept;
  logic                line;
  logic [3:0]          nbits;
  logic                data_xor;
  logic                par_bit;
  logic [TICK_W-1:0]   tick_len;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  always_ff @(posedge clk) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], cts_n};
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign tx_ready = cts_ok && ((state_q == IDLE) || ((state_q == STOP) && period_done));
  assign accept   = tx_valid && tx_ready;
  assign nbits    = clamp_bits(num_bits, MAX_BITS);
  assign tick_len = (state_q == STOP) ? stop_ticks(stop_q, OVERSAMPLE) : TICK_W'(OVERSAMPLE);

  // Parity is settled at accept so the frame is independent of later input changes.
  always_comb begin
    data_xor = 1'b0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (i < 32'(nbits)) data_xor = data_xor ^ tx_data[i];
    end
    if (parity_stick) par_bit = ~parity_ev;
    else              par_bit = parity_ev ? data_xor : ~data_xor;
  end

  always_comb begin
    line = 1'b1;
    unique case (state_q)
      IDLE:    line = 1'b1;
      START:   line = 1'b0;
      DATA:    line = shift_q[0];
      PARITY:  line = par_q;
      STOP:    line = 1'b1;
      default: line = 1'b1;
    endcase
  end

  uart_bit_timer #(
    .Width(TICK_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .baud_ce    (baud_ce),
    .load       (accept || (state_q == IDLE)),
    .length     (tick_len),
    .period_done(period_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      stop_q    <= STOP_1;
      stx_q     <= 1'b1;
      busy_n_q  <= 1'b1;
    end else begin
      stx_q <= line & ~break_en;
      if (accept) begin
        shift_q   <= tx_data;
        bit_cnt_q <= nbits - 4'd1;
        par_q     <= par_bit;
        par_en_q  <= parity_en;
        stop_q    <= stop_cfg;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= START;
            busy_n_q <= 1'b0;
          end
        end
        START: begin
          if (period_done) state_q <= DATA;
        end
        DATA: begin
          if (period_done) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q - 4'd1;
            if (bit_cnt_q == 4'd0) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (period_done) state_q <= STOP;
        end
        STOP: begin
          if (period_done) begin
            state_q  <= accept ? START : IDLE;
            busy_n_q <= ~accept;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stx    = stx_q;
  assign busy_n = busy_n_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: directed and random frames against a
// per-clock waveform model of the serial line.
module tb_uart_tx_param;

  localparam int unsigned MaxBits = 9;
  localparam int unsigned Os      = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               baud_ce = 1'b1;
  logic               tx_valid = 1'b0;
  logic               tx_ready;
  logic [MaxBits-1:0] tx_data = '0;
  logic [3:0]         num_bits = 4'd8;
  logic [1:0]         stop_cfg = 2'b00;
  logic               parity_en = 1'b0;
  logic               parity_ev = 1'b0;
  logic               parity_stick = 1'b0;
  logic               break_en = 1'b0;
  logic               cts_n = 1'b0;
  logic               stx;
  logic               busy_n;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  bit exp_q[$];

  uart_tx_param #(
    .MAX_BITS  (MaxBits),
    .OVERSAMPLE(Os)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_ce     (baud_ce),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .num_bits    (num_bits),
    .stop_cfg    (stop_cfg),
    .parity_en   (parity_en),
    .parity_ev   (parity_ev),
    .parity_stick(parity_stick),
    .break_en    (break_en),
`ifdef UART_TX_CTS_EN
    .cts_n       (cts_n),
`endif
    .stx         (stx),
    .busy_n      (busy_n)
  );

  always #5 clk = ~clk;

  // Inputs are stable from #1 after posedge until the next posedge.
  always @(negedge clk) if (!rst && tx_valid && tx_ready) acc_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level for every clk of the frame, baud_ce high every clk.
  task automatic build_exp(input logic [8:0] d, input int nb, input int sc,
                           input bit pen, input bit pev, input bit pst);
    int nbc, ones, slen;
    logic [8:0] m;
    bit pb;
    exp_q.delete();
    nbc = (nb < 5) ? 5 : (nb > int'(MaxBits)) ? int'(MaxBits) : nb;
    repeat (Os) exp_q.push_back(1'b0);
    for (int i = 0; i < nbc; i++) repeat (Os) exp_q.push_back(d[i]);
    if (pen) begin
      m    = 9'((1 << nbc) - 1);
      ones = $countones(d & m);
      pb   = pst ? !pev : (pev ? (ones % 2 == 1) : (ones % 2 == 0));
      repeat (Os) exp_q.push_back(pb);
    end
    slen = (sc == 0) ? Os : (sc == 1) ? (Os * 3) / 2 : 2 * Os;
    repeat (slen) exp_q.push_back(1'b1);
  endtask

  task automatic start_frame(input logic [8:0] d, input int nb, input int sc,
                             input bit pen, input bit pev, input bit pst);
    tx_data      = d;
    num_bits     = 4'(nb);
    stop_cfg     = 2'(sc);
    parity_en    = pen;
    parity_ev    = pev;
    parity_stick = pst;
    tx_valid     = 1'b1;
    check("ready_idle", tx_ready, 1);
    @(posedge clk) #1;
  endtask

  // Entered #1 after the accept edge. Checks every clk of the frame.
  task automatic run_frame(input logic [8:0] d, input int nb, input int sc,
                           input bit pen, input bit pev, input bit pst,
                           input int brk_at, input int rst_at,
                           input bit chain, input logic [8:0] nd);
    int  len;
    bit  brk;
    logic exp_stx;
    build_exp(d, nb, sc, pen, pev, pst);
    len     = exp_q.size();
    exp_stx = 1'b1;
    for (int k = 0; k <= len; k++) begin
      check("stx", stx, exp_stx);
      check("busy_n", busy_n, (k < len) ? 0 : 1);
      check("tx_ready", tx_ready, (k >= len - 1) ? 1 : 0);
      if (k == 0) begin
        if (chain) begin
          tx_data = nd;
        end else begin
          tx_valid     = 1'b0;
          tx_data      = 9'($urandom);
          num_bits     = 4'($urandom);
          stop_cfg     = 2'($urandom);
          parity_en    = 1'($urandom);
          parity_ev    = 1'($urandom);
          parity_stick = 1'($urandom);
        end
      end
      if (k == rst_at) begin
        rst = 1'b1;
        @(posedge clk) #1;
        check("rst_stx", stx, 1);
        check("rst_busy_n", busy_n, 1);
        check("rst_ready", tx_ready, 1);
        rst      = 1'b0;
        break_en = 1'b0;
        return;
      end
      brk      = (brk_at >= 0) && (k >= brk_at) && (k < brk_at + 40);
      break_en = brk;
      exp_stx  = (k < len) ? (exp_q[k] & ~brk) : 1'b1;
      @(posedge clk) #1;
      if (chain && k == len - 1) return;
    end
    break_en = 1'b0;
    check("stx_end", stx, exp_stx);
  endtask

  initial begin
    int a0;
    logic [8:0] d;
    int nb, sc;
    bit pen, pev, pst;

    repeat (3) @(posedge clk);
    #1;
    check("reset_stx", stx, 1);
    check("reset_busy_n", busy_n, 1);
    check("reset_ready", tx_ready, 1);
    rst = 1'b0;
    @(posedge clk) #1;
    check("idle_stx", stx, 1);

    // 8N1 0x55
    start_frame(9'h055, 8, 0, 0, 0, 0);
    run_frame(9'h055, 8, 0, 0, 0, 0, -1, -1, 0, '0);
    // 5 bits, 1.5 stop, then the same with num_bits clamped up from 3
    start_frame(9'h01F, 5, 1, 0, 0, 0);
    run_frame(9'h01F, 5, 1, 0, 0, 0, -1, -1, 0, '0);
    start_frame(9'h01F, 3, 1, 0, 0, 0);
    run_frame(9'h01F, 3, 1, 0, 0, 0, -1, -1, 0, '0);
    // 9 bits even parity, then stick parity
    start_frame(9'h1A5, 9, 0, 1, 1, 0);
    run_frame(9'h1A5, 9, 0, 1, 1, 0, -1, -1, 0, '0);
    start_frame(9'h1A5, 9, 0, 1, 1, 1);
    run_frame(9'h1A5, 9, 0, 1, 1, 1, -1, -1, 0, '0);
    // num_bits above MAX_BITS, odd parity, 2 stop bits
    start_frame(9'h0C3, 15, 3, 1, 0, 0);
    run_frame(9'h0C3, 15, 3, 1, 0, 0, -1, -1, 0, '0);

    // Back-to-back with tx_valid held high
    a0 = acc_cnt;
    start_frame(9'h0A3, 8, 0, 0, 0, 0);
    run_frame(9'h0A3, 8, 0, 0, 0, 0, -1, -1, 1, 9'h03C);
    run_frame(9'h03C, 8, 0, 0, 0, 0, -1, -1, 0, '0);
    check("b2b_accepts", acc_cnt - a0, 2);

    // Break for 40 clks mid-DATA
    start_frame(9'h0FF, 8, 0, 1, 1, 0);
    run_frame(9'h0FF, 8, 0, 1, 1, 0, Os + 20, -1, 0, '0);

    // Reset at data bit 3, then a fresh frame
    a0 = acc_cnt;
    start_frame(9'h0B6, 8, 0, 0, 0, 0);
    run_frame(9'h0B6, 8, 0, 0, 0, 0, -1, Os * 4 + 5, 0, '0);
    repeat (Os * 2) begin
      @(posedge clk) #1;
      check("idle_after_rst", {busy_n, stx}, 2'b11);
    end
    check("rst_accepts", acc_cnt - a0, 1);
    start_frame(9'h096, 7, 2, 1, 0, 0);
    run_frame(9'h096, 7, 2, 1, 0, 0, -1, -1, 0, '0);

    // Random frames, with some idle clks in between
    for (int i = 0; i < 24; i++) begin
      d   = 9'($urandom);
      nb  = int'($urandom_range(0, 15));
      sc  = int'($urandom_range(0, 3));
      pen = 1'($urandom);
      pev = 1'($urandom);
      pst = 1'($urandom);
      start_frame(d, nb, sc, pen, pev, pst);
      run_frame(d, nb, sc, pen, pev, pst, -1, -1, 0, '0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
